fib_index_finder: RTL
=====================

// Module: fib_index_finder
// PURPOSE
//  Inverse of the Fibonacci calculator: takes a 5-bit value V, iterates the Fibonacci sequence, and returns
//  the largest index n with F(n) <= V, plus a flag for F(n) == V.
//  Sequence convention matches the calculator: F(0)=1, F(1)=1, F(2)=2, ..., F(7)=21.
//  Sits beside the calculator in the Fibonacci datapath (cross-check / round-trip) under a start/busy/done handshake.
// PARAMETERS
//  N_WIDTH  3  width of index n; largest index searched N_MAX = 2**N_WIDTH-1
//  V_WIDTH  5  width of input value V; internal sequence registers are V_WIDTH+1 bits (no overflow at F(N_MAX+1))
// PORTS
//  clk    in   1        rising-edge clock, single clock domain
//  rst    in   1        synchronous, active-high reset
//  start  in   1        request; sampled only in IDLE
//  value  in   V_WIDTH  target V; captured on the edge that accepts start
//  busy   out  1        high while in CALC
//  done   out  1        one-cycle pulse, high only in DONE
//  n      out  N_WIDTH  result index; held until next accepted start
//  found  out  1        1 iff F(n) == V; held with n
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=IDLE; busy=0, done=0, n=0, found=0; internal regs cleared.
//   - Reset wins over every other event, including mid-CALC (computation aborted, no done).
//  Registers: tgt (V_WIDTH), cur/nxt (V_WIDTH+1), idx (N_WIDTH).
//  States:
//   - IDLE: start=1 -> tgt<=value, cur<=1, nxt<=1, idx<=0, go CALC. start=0 -> stay.
//   - CALC, first match wins:
//     a) tgt==0 -> n<=0, found<=0, go DONE.
//     b) nxt>tgt OR idx==N_MAX -> n<=idx, found<=(cur==tgt), go DONE.
//     c) otherwise -> cur<=nxt, nxt<=cur+nxt, idx<=idx+1, stay.
//   - DONE: unconditionally -> IDLE next edge.
//  Outputs: busy, done decoded from state; n, found registered, loaded only on CALC->DONE.
//  Handshake:
//   - start ignored in CALC and DONE (no queueing); value is don't-care after capture.
//   - start held high continuously -> back-to-back ops, one IDLE cycle between done and next busy.
//  Latency:
//   - start sampled at edge E; busy=1 after E; done=1 after edge E+n+1, n = returned index.
//   - V=0 -> done after E+1.
//   - Worst case V>=21 (n=7) -> done after E+8.
//  Comparisons unsigned; tgt zero-extended to V_WIDTH+1 for compare; cur+nxt computed at V_WIDTH+1 bits.
//  Boundaries:
//   - V=0 -> n=0, found=0.
//   - V=1 -> n=1, found=1 (largest index wins).
//   - V>F(N_MAX), e.g. 22..31 -> n=N_MAX, found=0.
//   - Non-Fibonacci V, e.g. 4 -> floor index n=3, found=0.
// TESTING
//  1. rst=1 one edge mid-CALC (V=21 started 3 edges earlier) -> busy=0, done never pulses, n=0, found=0.
//  2. V=13, start one cycle -> busy 7 cycles, done pulse after edge E+7, n=6, found=1.
//  3. V=0 -> done after E+1, n=0, found=0; V=1 -> done after E+2, n=1, found=1.
//  4. V=4 -> n=3, found=0; V=31 -> n=7, found=0, done after E+8.
//  5. start re-pulsed with V=2 while busy on V=21 -> ignored; result n=7, found=1.
//  6. Sweep V=0..31 with start held high -> each result equals the floor-index golden model,
//     one idle cycle between ops.

Source files
------------

// File: rtl/fib_index_finder_if.sv
// Start/busy/done handshake bundle for fib_index_finder.
//   start  requester -> finder  request, sampled only while the finder is idle
//   value  requester -> finder  target V, captured on the accepting edge
//   busy   finder -> requester  high while the search iterates
//   done   finder -> requester  one-cycle completion pulse
//   n      finder -> requester  largest index with F(n) <= V, held until next accept
//   found  finder -> requester  1 iff F(n) == V, held with n
interface fib_index_finder_if #(
  parameter int unsigned N_WIDTH = 3,
  parameter int unsigned V_WIDTH = 5
);

  logic               start;
  logic [V_WIDTH-1:0] value;
  logic               busy;
  logic               done;
  logic [N_WIDTH-1:0] n;
  logic               found;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  n,
    input  found
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output n,
    output found
  );

endinterface

// File: rtl/fib_index_finder.sv
// Inverse Fibonacci lookup: walks F(0)=1, F(1)=1, F(2)=2, ... and returns the largest
// index n (capped at 2**N_WIDTH-1) with F(n) <= V, plus found = (F(n) == V).
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any search in flight without a done pulse
//   bus  slave side of fib_index_finder_if (start/value in, busy/done/n/found out)
// Latency: start accepted at edge E, done pulses after edge E+n+1 (E+1 when V=0).
module fib_index_finder #(
  parameter int unsigned N_WIDTH = 3,
  parameter int unsigned V_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  fib_index_finder_if.slave bus
);

  // One spare bit so the sequence step past F(N_MAX) never wraps.
  localparam int unsigned S_WIDTH = V_WIDTH + 1;
  localparam logic [N_WIDTH-1:0] N_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e             state_q;
  logic [V_WIDTH-1:0] tgt_q;
  logic [S_WIDTH-1:0] cur_q;
  logic [S_WIDTH-1:0] nxt_q;
  logic [N_WIDTH-1:0] idx_q;
  logic [N_WIDTH-1:0] n_q;
  logic               found_q;
  logic               busy_q;
  logic               done_q;

  logic [S_WIDTH-1:0] tgt_ext;
  logic [S_WIDTH-1:0] sum;

  assign tgt_ext = {1'b0, tgt_q};
  assign sum     = cur_q + nxt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            tgt_q   <= bus.value;
            cur_q   <= S_WIDTH'(1);
            nxt_q   <= S_WIDTH'(1);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end

        StCalc: begin
          if (tgt_q == '0) begin
            // No Fibonacci term is <= 0; report index 0, not found.
            n_q     <= '0;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if ((nxt_q > tgt_ext) || (idx_q == N_MAX)) begin
            // cur is the last term not exceeding the target (or the cap was hit).
            n_q     <= idx_q;
            found_q <= (cur_q == tgt_ext);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cur_q <= nxt_q;
            nxt_q <= sum;
            idx_q <= idx_q + 1'b1;
          end
        end

        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.n     = n_q;
  assign bus.found = found_q;

endmodule
